// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit-side byte buffer and handshake sequencer feeding a UART
// transmitter. Host bytes are queued in a circular FIFO; one xmitH pulse is
// issued per byte. Before the next byte is started, the transmitter must drop
// xmit_doneH (byte accepted) and raise it again (frame complete).
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   synchronous active-high reset
//   wr_enH      in   write strobe, one byte per cycle
//   wr_dataH    in   byte to enqueue
//   fullH       out  FIFO holds 2**DEPTH_LOG2 bytes
//   emptyH      out  FIFO holds no bytes
//   levelH      out  occupancy 0..2**DEPTH_LOG2
//   xmitH       out  one-cycle start pulse to the transmitter
//   xmit_dataH  out  byte presented to the transmitter, held until next pop
//   xmit_doneH  in   transmitter idle/complete level
//
// Optional feature (macro UART_TX_FIFO_OVF_EN):
//   ovf_errH    out  sticky flag, set by any write attempted while full
//   clr_ovfH    in   clears ovf_errH unless a new overflow occurs that edge

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WORD_LEN   = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wr_enH,
  input  logic [WORD_LEN-1:0]   wr_dataH,
  output logic                  fullH,
  output logic                  emptyH,
  output logic [DEPTH_LOG2:0]   levelH,
  output logic                  xmitH,
  output logic [WORD_LEN-1:0]   xmit_dataH,
  input  logic                  xmit_doneH
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                  ovf_errH,
  input  logic                  clr_ovfH
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACK  = 2'b01,
    S_BUSY = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [WORD_LEN-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    xmit_q, xmit_d;
  logic [WORD_LEN-1:0]     xmit_data_q;
  logic                    full_s, empty_s, wr_acc_s, pop_s;

  assign full_s   = (level_q == LVL_FULL);
  assign empty_s  = (level_q == LVL_ZERO);
  // A write attempted while full is dropped, even if a pop frees a slot this edge.
  assign wr_acc_s = wr_enH & ~full_s;

  assign fullH      = full_s;
  assign emptyH     = empty_s;
  assign levelH     = level_q;
  assign xmitH      = xmit_q;
  assign xmit_dataH = xmit_data_q;

  // Next-state, start pulse and pop decision for the handshake sequencer.
  always_comb begin
    state_d = state_q;
    xmit_d  = 1'b0;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Uses the registered level, so a byte is popped no earlier than the
        // edge after it was written.
        if (!empty_s && xmit_doneH) begin
          state_d = S_ACK;
          xmit_d  = 1'b1;
          pop_s   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (!xmit_doneH) begin
          state_d = S_BUSY;
        end else begin
          state_d = S_ACK;
        end
      end
      S_BUSY: begin
        if (xmit_doneH) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end
      default: begin
        state_d = S_IDLE;
        xmit_d  = 1'b0;
      end
    endcase
  end

  // Occupancy change: a simultaneous accepted write and pop cancel out.
  always_comb begin
    level_d = level_q;
    case ({wr_acc_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Sequencer state, pointers, level and transmitter-facing outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      level_q     <= LVL_ZERO;
      xmit_q      <= 1'b0;
      xmit_data_q <= {WORD_LEN{1'b0}};
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      xmit_q   <= xmit_d;
      if (wr_acc_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        xmit_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents deliberately survive reset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= wr_dataH;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;
  assign ovf_errH = ovf_q;

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ovf_q <= 1'b0;
    end else if (wr_enH && full_s) begin
      ovf_q <= 1'b1;
    end else if (clr_ovfH) begin
      ovf_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_enH = 1'b0;
  logic [7:0]  wr_dataH = 8'h00;
  logic        fullH, emptyH, xmitH;
  logic [DL:0] levelH;
  logic [7:0]  xmit_dataH;
  logic        xmit_doneH = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
  logic        ovf_errH;
  logic        clr_ovfH = 1'b0;
`endif

  uart_tx_fifo #(.DEPTH_LOG2(DL), .WORD_LEN(8)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wr_enH     (wr_enH),
    .wr_dataH   (wr_dataH),
    .fullH      (fullH),
    .emptyH     (emptyH),
    .levelH     (levelH),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_errH   (ovf_errH),
    .clr_ovfH   (clr_ovfH)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a queue of pending bytes plus a record of whether a
  // handed-off byte still awaits the transmitter's low-then-high done level.
  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         in_flight = 1'b0;
  bit         seen_low  = 1'b0;
  logic       exp_xmit  = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  logic       exp_ovf   = 1'b0;

  // Transmitter model knobs.
  int tx_phase = 0;
  int tx_cnt   = 0;
  int tx_lat   = 1;
  int frame    = 160;
  bit tx_hold  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit full_m, pop_m;
    if (sys_rst) begin
      q.delete();
      in_flight = 1'b0;
      seen_low  = 1'b0;
      exp_xmit  = 1'b0;
      exp_data  = 8'h00;
      exp_ovf   = 1'b0;
    end else begin
      full_m = (q.size() == DEPTH);
      pop_m  = !in_flight && (q.size() != 0) && xmit_doneH;
      exp_xmit = pop_m;
      if (pop_m) begin
        exp_data = q.pop_front();
        sent.push_back(exp_data);
        in_flight = 1'b1;
        seen_low  = 1'b0;
      end else if (in_flight) begin
        if (!seen_low) begin
          if (!xmit_doneH) seen_low = 1'b1;
        end else if (xmit_doneH) begin
          in_flight = 1'b0;
        end
      end
      if (wr_enH && !full_m) q.push_back(wr_dataH);
`ifdef UART_TX_FIFO_OVF_EN
      if (wr_enH && full_m) exp_ovf = 1'b1;
      else if (clr_ovfH) exp_ovf = 1'b0;
`endif
    end
  endtask

  task automatic compare_all();
    chk("xmitH", 32'(xmitH), 32'(exp_xmit));
    chk("xmit_dataH", 32'(xmit_dataH), 32'(exp_data));
    chk("levelH", 32'(levelH), q.size());
    chk("emptyH", 32'(emptyH), 32'(q.size() == 0));
    chk("fullH", 32'(fullH), 32'(q.size() == DEPTH));
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_errH", 32'(ovf_errH), 32'(exp_ovf));
`endif
  endtask

  task automatic tx_step();
    if (tx_hold) begin
      xmit_doneH = 1'b0;
    end else begin
      case (tx_phase)
        0: if (xmitH) begin tx_phase = 1; tx_cnt = tx_lat; end
        1: if (tx_cnt == 0) begin xmit_doneH = 1'b0; tx_phase = 2; tx_cnt = frame; end
           else tx_cnt--;
        2: if (tx_cnt == 0) begin xmit_doneH = 1'b1; tx_phase = 0; end
           else tx_cnt--;
        default: tx_phase = 0;
      endcase
    end
  endtask

  task automatic tx_reset();
    tx_phase   = 0;
    xmit_doneH = 1'b1;
  endtask

  task automatic cycle(input logic wr, input logic [7:0] d);
    wr_enH   = wr;
    wr_dataH = d;
    @(posedge sys_clk);
    model_edge();
    #1;
    compare_all();
    tx_step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || in_flight || tx_phase != 0) && n < budget) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'd0);
  endtask

  initial begin
    // 1: reset and single byte latency
    cycle(1'b0, 8'h00);
    sys_rst = 1'b0;
    chk("rst_level", 32'(levelH), 32'd0);
    chk("rst_empty", 32'(emptyH), 32'd1);
    chk("rst_data", 32'(xmit_dataH), 32'h00);
    cycle(1'b1, 8'h55);
    chk("t1_level1", 32'(levelH), 32'd1);
    chk("t1_nopulse", 32'(xmitH), 32'd0);
    cycle(1'b0, 8'h00);
    chk("t1_pulse", 32'(xmitH), 32'd1);
    chk("t1_data", 32'(xmit_dataH), 32'h55);
    chk("t1_level0", 32'(levelH), 32'd0);
    chk("t1_empty", 32'(emptyH), 32'd1);
    cycle(1'b0, 8'h00);
    chk("t1_pulse_end", 32'(xmitH), 32'd0);
    drain(400);

    // 2: three bytes through a slow transmitter
    sent.delete();
    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hB2);
    cycle(1'b1, 8'hC3);
    drain(2000);
    chk("t2_count", sent.size(), 32'd3);
    if (sent.size() == 3) begin
      chk("t2_b0", 32'(sent[0]), 32'hA1);
      chk("t2_b1", 32'(sent[1]), 32'hB2);
      chk("t2_b2", 32'(sent[2]), 32'hC3);
    end

    // 3: fill while the transmitter is held busy, then drain
    tx_hold = 1'b1;
    xmit_doneH = 1'b0;
    sent.delete();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
    chk("t3_full", 32'(fullH), 32'd1);
    chk("t3_level16", 32'(levelH), 32'd16);
    cycle(1'b1, 8'hFF);
    chk("t3_drop_level", 32'(levelH), 32'd16);
`ifdef UART_TX_FIFO_OVF_EN
    // 6: sticky overflow flag
    chk("t6_ovf_set", 32'(ovf_errH), 32'd1);
    clr_ovfH = 1'b1;
    cycle(1'b0, 8'h00);
    chk("t6_ovf_clr", 32'(ovf_errH), 32'd0);
    cycle(1'b1, 8'hFE);
    chk("t6_ovf_win", 32'(ovf_errH), 32'd1);
    cycle(1'b0, 8'h00);
    clr_ovfH = 1'b0;
`endif
    tx_hold = 1'b0;
    tx_reset();
    frame = 4;
    drain(1000);
    chk("t3_count", sent.size(), 32'd16);
    for (int i = 0; i < 16 && i < sent.size(); i++) chk("t3_order", 32'(sent[i]), i);

    // 4: wrap-around rounds
    for (int r = 0; r < 3; r++) begin
      sent.delete();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + r * 10 + i));
      drain(1000);
      chk("t4_level0", 32'(levelH), 32'd0);
      chk("t4_count", sent.size(), 32'd10);
      for (int i = 0; i < 10 && i < sent.size(); i++)
        chk("t4_order", 32'(sent[i]), 32'(8'h30 + r * 10 + i));
    end

    // 5: write coincident with pop, then reset while busy
    sent.delete();
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    chk("t5_level_hold", 32'(levelH), 32'd1);
    chk("t5_pulse", 32'(xmitH), 32'd1);
    chk("t5_data", 32'(xmit_dataH), 32'h11);
    drain(1000);
    chk("t5_second", sent.size() == 2 ? 32'(sent[1]) : 32'hDEAD, 32'h22);
    frame = 40;
    cycle(1'b1, 8'h33);
    cycle(1'b1, 8'h44);
    begin
      int n;
      n = 0;
      while (!(in_flight && seen_low) && n < 100) begin
        cycle(1'b0, 8'h00);
        n++;
      end
      chk("t5_busy_timeout", 32'(n >= 100), 32'd0);
    end
    sys_rst = 1'b1;
    cycle(1'b0, 8'h00);
    sys_rst = 1'b0;
    tx_reset();
    chk("t5_rst_xmit", 32'(xmitH), 32'd0);
    chk("t5_rst_level", 32'(levelH), 32'd0);
    chk("t5_rst_data", 32'(xmit_dataH), 32'h00);
    chk("t5_rst_empty", 32'(emptyH), 32'd1);
    cycle(1'b0, 8'h00);
    chk("t5_rst_quiet", 32'(xmitH), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (tx_phase == 0) begin
        frame  = $urandom_range(30, 1);
        tx_lat = $urandom_range(3, 0);
      end
`ifdef UART_TX_FIFO_OVF_EN
      clr_ovfH = ($urandom_range(7, 0) == 0);
`endif
      sys_rst = ($urandom_range(799, 0) == 0);
      cycle(($urandom_range(2, 0) == 0), 8'($urandom));
      if (sys_rst) tx_reset();
    end
    sys_rst = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    clr_ovfH = 1'b0;
`endif
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
